// File: rtl/caliptra_fpga_clk_step_ctrl_if.sv
// Host-side control/status bundle for the clock step controller.
// master: register block (drives go/mode/count/masks, reads status)
// slave : the controller itself
`timescale 1ns/1ps
interface caliptra_fpga_clk_step_ctrl_if #(
    parameter int unsigned NUM_CH  = 2,
    parameter int unsigned CNT_W   = 32,
    parameter int unsigned STAMP_W = 64
);
    logic                go_i;
    logic [1:0]          mode_i;
    logic [CNT_W-1:0]    cycle_count_i;
    logic [NUM_CH-1:0]   ch_mask_i;
    logic [NUM_CH-1:0]   trig_i;
    logic [NUM_CH-1:0]   trig_mask_i;
    logic                stop_i;
    logic                cnt_clr_i;
    logic [NUM_CH-1:0]   clk_en_o;
    logic                busy_o;
    logic                done_o;
    logic [1:0]          reason_o;
    logic [CNT_W-1:0]    cycles_left_o;
    logic [STAMP_W-1:0]  en_cycles_o;
    logic                go_err_o;

    modport master (
        output go_i, mode_i, cycle_count_i, ch_mask_i, trig_i, trig_mask_i, stop_i, cnt_clr_i,
        input  clk_en_o, busy_o, done_o, reason_o, cycles_left_o, en_cycles_o, go_err_o
    );

    modport slave (
        input  go_i, mode_i, cycle_count_i, ch_mask_i, trig_i, trig_mask_i, stop_i, cnt_clr_i,
        output clk_en_o, busy_o, done_o, reason_o, cycles_left_o, en_cycles_o, go_err_o
    );
endinterface

// File: rtl/caliptra_fpga_clk_step_ctrl.sv
// Single-step / free-run clock-enable controller for the FPGA sync wrapper.
// Drives NUM_CH registered enables into glitch-free clock gates, with count,
// trigger and host-abort halts plus a sticky halt-reason status.
// Ports:
//   aclk - free-running clock (posedge)
//   rst  - asynchronous active-high reset
//   bus  - control/status bundle (slave side): go/mode/count/masks/trig/stop/clear
//          in; clk_en/busy/done/reason/cycles_left/en_cycles/go_err out
`timescale 1ns/1ps
module caliptra_fpga_clk_step_ctrl #(
    parameter int unsigned NUM_CH  = 2,
    parameter int unsigned CNT_W   = 32,
    parameter int unsigned STAMP_W = 64
) (
    input  logic                          aclk,
    input  logic                          rst,
    caliptra_fpga_clk_step_ctrl_if.slave  bus
);

    localparam int unsigned REASON_W = 2;
    localparam logic [REASON_W-1:0] RSN_COUNT = REASON_W'(1);
    localparam logic [REASON_W-1:0] RSN_TRIG  = REASON_W'(2);
    localparam logic [REASON_W-1:0] RSN_STOP  = REASON_W'(3);

    typedef enum logic {S_IDLE, S_RUN} state_e;

    state_e              state_q, state_d;
    logic [NUM_CH-1:0]   clk_en_q, clk_en_d;
    logic [NUM_CH-1:0]   trig_mask_q, trig_mask_d;
    logic                free_q, free_d;
    logic                trig_mode_q, trig_mode_d;
    logic [CNT_W-1:0]    left_q, left_d;
    logic                done_q, done_d;
    logic [REASON_W-1:0] reason_q, reason_d;
    logic                busy_q, busy_d;
    logic                go_err_q, go_err_d;
    logic [STAMP_W-1:0]  en_cyc_q;

    logic halt_stop, halt_trig, halt_cnt;

    // Halt sources evaluated in a RUN cycle; the cycle itself still counts as enabled.
    always_comb begin
        halt_stop = bus.stop_i;
        halt_trig = trig_mode_q && (|(bus.trig_i & trig_mask_q));
        halt_cnt  = !free_q && (left_q == CNT_W'(1));
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d     = state_q;
        clk_en_d    = clk_en_q;
        trig_mask_d = trig_mask_q;
        free_d      = free_q;
        trig_mode_d = trig_mode_q;
        left_d      = left_q;
        done_d      = 1'b0;
        reason_d    = reason_q;
        go_err_d    = go_err_q;

        case (state_q)
            S_IDLE: begin
                if (bus.go_i) begin
                    free_d      = bus.mode_i[0];
                    trig_mode_d = bus.mode_i[1];
                    trig_mask_d = bus.trig_mask_i;
                    go_err_d    = 1'b0;
                    if (!bus.mode_i[0] && (bus.cycle_count_i == '0)) begin
                        // Zero-length step: report completion without ever enabling.
                        done_d   = 1'b1;
                        reason_d = RSN_COUNT;
                        left_d   = '0;
                    end else begin
                        state_d  = S_RUN;
                        clk_en_d = bus.ch_mask_i;
                        left_d   = bus.mode_i[0] ? '0 : bus.cycle_count_i;
                    end
                end
            end
            S_RUN: begin
                if (bus.go_i) begin
                    go_err_d = 1'b1;
                end
                if (!free_q) begin
                    left_d = left_q - CNT_W'(1);
                end
                if (halt_stop || halt_trig || halt_cnt) begin
                    state_d  = S_IDLE;
                    clk_en_d = '0;
                    done_d   = 1'b1;
                    reason_d = halt_stop ? RSN_STOP : (halt_trig ? RSN_TRIG : RSN_COUNT);
                end
            end
            default: begin
                state_d  = S_IDLE;
                clk_en_d = '0;
            end
        endcase

        busy_d = (state_d == S_RUN);
    end

    // State and registered outputs.
    always_ff @(posedge aclk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            clk_en_q    <= '0;
            trig_mask_q <= '0;
            free_q      <= 1'b0;
            trig_mode_q <= 1'b0;
            left_q      <= '0;
            done_q      <= 1'b0;
            reason_q    <= '0;
            busy_q      <= 1'b0;
            go_err_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            clk_en_q    <= clk_en_d;
            trig_mask_q <= trig_mask_d;
            free_q      <= free_d;
            trig_mode_q <= trig_mode_d;
            left_q      <= left_d;
            done_q      <= done_d;
            reason_q    <= reason_d;
            busy_q      <= busy_d;
            go_err_q    <= go_err_d;
        end
    end

    // Enabled-cycle stamp; clear takes precedence over a same-cycle increment.
    always_ff @(posedge aclk or posedge rst) begin
        if (rst) begin
            en_cyc_q <= '0;
        end else if (bus.cnt_clr_i) begin
            en_cyc_q <= '0;
        end else if (|clk_en_q) begin
            en_cyc_q <= en_cyc_q + STAMP_W'(1);
        end
    end

    assign bus.clk_en_o      = clk_en_q;
    assign bus.busy_o        = busy_q;
    assign bus.done_o        = done_q;
    assign bus.reason_o      = reason_q;
    assign bus.cycles_left_o = left_q;
    assign bus.en_cycles_o   = en_cyc_q;
    assign bus.go_err_o      = go_err_q;

endmodule
